hilo_mdu_ctrl: RTL

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair beside the single-cycle ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU from the control unit, iterates one bit per cycle, and publishes a 64-bit result into HI/LO. It drives a fetch stall whenever the pipeline tries to read or write HI/LO, or issue a new operation, while a computation is in flight.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_step.sv | 43 ++++
 rtl/hilo_mdu_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Divider support is selected by MDU_DIV_EN in the files that import this package.
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   // LO value published for a divide by zero
   localparam logic [MDU_WIDTH-1:0] MDU_DIV0_LO = '1;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring-divide step.
// The trial-subtract path exists only when MDU_DIV_EN is defined.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
`ifdef MDU_DIV_EN
   input  logic               is_div,
`endif
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   m,
   output logic [2*WIDTH-1:0] acc_next
);

   localparam int unsigned AW = 2 * WIDTH;

   logic [WIDTH:0] sum;

   // acc = {partial product, remaining multiplier bits}; LSB selects the add
   assign sum = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});

`ifdef MDU_DIV_EN
   logic [WIDTH:0] trial;

   // acc = {partial remainder, dividend/quotient}; borrow out means restore
   assign trial = acc[AW-1:WIDTH-1] - {1'b0, m};
`endif

   always_comb begin
      acc_next = {sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
      if (is_div) begin
         if (trial[WIDTH]) begin
            acc_next = {acc[AW-2:0], 1'b0};
         end else begin
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end
      end
`endif
   end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair, with fetch stall.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU are rejected with illegal.
module hilo_mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_rd,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             illegal
);

   localparam int unsigned AW = 2 * WIDTH;

   mdu_state_t       state, state_d;
   mdu_op_t          op_in;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] m, a_abs, b_abs, hi_res, lo_res;
   logic [AW-1:0]    acc, acc_step, prod_fix;
   logic             sa, sb, op_signed, op_is_div, last_iter;
   logic             accept, illegal_d, wr_ok;
`ifdef MDU_DIV_EN
   logic             div_q, div0_q;
`endif

   assign op_in     = mdu_op_t'(op);
   assign op_signed = (op_in == MULT) || (op_in == DIV);
   assign op_is_div = (op_in == DIV) || (op_in == DIVU);
   assign a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
   assign b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;

   assign busy  = (state != IDLE);
   assign stall = busy & (start | hilo_rd | wr_hi | wr_lo);

`ifdef MDU_DIV_EN
   // A zero divisor spends a single CALC cycle without iterating
   assign last_iter = div0_q || (cnt == CNT_W'(WIDTH - 1));
`else
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

   mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
      .is_div   (div_q),
`endif
      .acc      (acc),
      .m        (m),
      .acc_next (acc_step)
   );

   // Sign fixup of the magnitude result and HI/LO placement
   assign prod_fix = (sa ^ sb) ? -acc : acc;

   always_comb begin
      {hi_res, lo_res} = prod_fix;
`ifdef MDU_DIV_EN
      if (div0_q) begin
         lo_res = WIDTH'(MDU_DIV0_LO);
         hi_res = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end else if (div_q) begin
         lo_res = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         hi_res = sa ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
      end
`endif
   end

   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      illegal_d = 1'b0;
      wr_ok     = 1'b0;
      case (state)
         IDLE: begin
            wr_ok = ~start;
            if (start) begin
`ifdef MDU_DIV_EN
               accept  = 1'b1;
               state_d = CALC;
`else
               if (op_is_div) begin
                  illegal_d = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = CALC;
               end
`endif
            end
         end
         CALC:    if (last_iter) state_d = SIGN;
         SIGN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         m       <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         illegal <= 1'b0;
`ifdef MDU_DIV_EN
         div_q   <= 1'b0;
         div0_q  <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         done    <= 1'b0;
         illegal <= illegal_d;
         if (accept) begin
            cnt <= '0;
            acc <= {{WIDTH{1'b0}}, a_abs};
            m   <= b_abs;
            sa  <= op_signed & a[WIDTH-1];
            sb  <= op_signed & b[WIDTH-1];
`ifdef MDU_DIV_EN
            div_q  <= op_is_div;
            div0_q <= op_is_div && (b == '0);
`endif
         end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
`ifdef MDU_DIV_EN
            if (!div0_q) acc <= acc_step;
`else
            acc <= acc_step;
`endif
         end else if (state == SIGN) begin
            hi   <= hi_res;
            lo   <= lo_res;
            done <= 1'b1;
         end else if (wr_ok) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
         end
      end
   end

endmodule
